// File: rtl/arb_burst_sched.sv
// Four-requester round-robin burst scheduler: holds a one-hot grant for len+1 beats
// (or until early release) and inserts one idle turnaround cycle between bursts.
module arb_burst_sched #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic [3:0]         done,
    input  logic               en,
    output logic [3:0]         gnt,
    output logic [1:0]         gnt_id,
    output logic               gnt_start,
    output logic               busy,
    output logic [LEN_W-1:0]   beats_left
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    logic [1:0]       last;
    logic             found;
    logic [1:0]       win;
    logic [LEN_W-1:0] win_len;
    logic             last_beat;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = last;
        idx   = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_len   = req_len[int'(win)*LEN_W +: LEN_W];
    assign last_beat = (beats_left == '0) || done[gnt_id] || !req[gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 4'b0000;
            gnt_id     <= 2'd0;
            gnt_start  <= 1'b0;
            busy       <= 1'b0;
            beats_left <= '0;
            last       <= 2'd3;
        end else begin
            case (state)
                GRANT: begin
                    gnt_start <= 1'b0;
                    if (last_beat) begin
                        state      <= GAP;
                        gnt        <= 4'b0000;
                        busy       <= 1'b0;
                        beats_left <= '0;
                    end else begin
                        beats_left <= beats_left - LEN_W'(1);
                    end
                end
                default: begin
                    // IDLE and the single GAP cycle both arbitrate; GAP falls to IDLE if nobody wins.
                    if (en && found) begin
                        state      <= GRANT;
                        gnt        <= 4'b0001 << win;
                        gnt_id     <= win;
                        gnt_start  <= 1'b1;
                        busy       <= 1'b1;
                        beats_left <= win_len;
                        last       <= win;
                    end else begin
                        state      <= IDLE;
                        gnt        <= 4'b0000;
                        gnt_start  <= 1'b0;
                        busy       <= 1'b0;
                        beats_left <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_burst_sched.sv
// Directed, table-driven bench for arb_burst_sched: each record is one cycle of inputs
// plus the outputs expected right after the following rising edge.
module tb_arb_burst_sched;

    localparam int LEN_W = 4;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [4*LEN_W-1:0] req_len;
    logic [3:0]         done;
    logic               en;
    logic [3:0]         gnt;
    logic [1:0]         gnt_id;
    logic               gnt_start;
    logic               busy;
    logic [LEN_W-1:0]   beats_left;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  done;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_id;
        logic        chk_id;
        logic        exp_start;
        logic [3:0]  exp_bl;
    } vec_t;

    vec_t vecs[$];

    arb_burst_sched #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .done       (done),
        .en         (en),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_start  (gnt_start),
        .busy       (busy),
        .beats_left (beats_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic [3:0] rq, logic [15:0] ln, logic [3:0] dn,
                                logic [3:0] g, logic [1:0] id, logic cid, logic st, logic [3:0] bl);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.len = ln; v.done = dn;
        v.exp_gnt = g; v.exp_id = id; v.chk_id = cid; v.exp_start = st; v.exp_bl = bl;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rq,
                                 input logic [15:0] ln, input logic [3:0] dn);
        rst = r; en = e; req = rq; req_len = ln; done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] g, input logic [1:0] id,
                               input logic cid, input logic st, input logic [3:0] bl);
        total++;
        if (gnt !== g) begin
            bad++;
            $display("[TB] FAIL %s.gnt got=%b want=%b", name, gnt, g);
        end
        total++;
        if (busy !== (g != 4'b0000)) begin
            bad++;
            $display("[TB] FAIL %s.busy got=%b want=%b", name, busy, (g != 4'b0000));
        end
        total++;
        if (gnt_start !== st) begin
            bad++;
            $display("[TB] FAIL %s.gnt_start got=%b want=%b", name, gnt_start, st);
        end
        total++;
        if (beats_left !== bl) begin
            bad++;
            $display("[TB] FAIL %s.beats_left got=%0d want=%0d", name, beats_left, bl);
        end
        if (cid) begin
            total++;
            if (gnt_id !== id) begin
                bad++;
                $display("[TB] FAIL %s.gnt_id got=%0d want=%0d", name, gnt_id, id);
            end
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; en = 1'b0; req = '0; req_len = '0; done = '0;

        // Single requester, 4-beat burst, gap, regrant.
        vecs.push_back(mk(1, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 1, 3));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 0, 2));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 1, 3));
        // All four requesting with single-beat bursts: rotation with gaps.
        vecs.push_back(mk(1, 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0010, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0100, 2, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 0, 1, 1, 0));
        // Early release by done in the 3rd grant cycle; foreign done ignored.
        vecs.push_back(mk(1, 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0100, 16'h0700, 4'b0000, 4'b0100, 2, 1, 1, 7));
        vecs.push_back(mk(0, 1, 4'b0100, 16'h0700, 4'b0001, 4'b0100, 2, 1, 0, 6));
        vecs.push_back(mk(0, 1, 4'b0100, 16'h0700, 4'b0000, 4'b0100, 2, 1, 0, 5));
        vecs.push_back(mk(0, 1, 4'b0100, 16'h0700, 4'b0100, 4'b0000, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 16'h0700, 4'b0000, 4'b0000, 2, 1, 0, 0));
        // Early release by req drop; another requester waits through one gap.
        vecs.push_back(mk(0, 1, 4'b0010, 16'h0050, 4'b0000, 4'b0010, 1, 1, 1, 5));
        vecs.push_back(mk(0, 1, 4'b1010, 16'h0050, 4'b0000, 4'b0010, 1, 1, 0, 4));
        vecs.push_back(mk(0, 1, 4'b1000, 16'h0050, 4'b0000, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1000, 16'h0050, 4'b0000, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1000, 16'h0050, 4'b0000, 4'b0000, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 16'h0050, 4'b0000, 4'b0000, 3, 1, 0, 0));
        // Enable gating: blocked when idle, ignored once a burst is running.
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0000, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0000, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h4444, 4'b0000, 4'b0001, 0, 1, 1, 4));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0001, 0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0001, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0001, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0001, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4444, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 16'h4444, 4'b0000, 4'b0010, 1, 1, 1, 4));
        // Reset mid-burst aborts and restores the pointer.
        vecs.push_back(mk(1, 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 1, 1, 3));
        vecs.push_back(mk(1, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1010, 16'h0000, 4'b0000, 4'b0010, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b1010, 16'h0000, 4'b0000, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1010, 16'h0000, 4'b0000, 4'b1000, 3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 4'b0000, 16'h0000, 4'b1111, 4'b0000, 3, 1, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].len, vecs[i].done);
            checkOutput($sformatf("v%0d", i), vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].chk_id,
                        vecs[i].exp_start, vecs[i].exp_bl);
        end

        // done coinciding with the natural last beat ends the burst once.
        applyStimulus(0, 1, 4'b0001, 16'h0001, 4'b0000);
        checkOutput("coinc.first", 4'b0001, 0, 1, 1, 1);
        applyStimulus(0, 1, 4'b0001, 16'h0001, 4'b0000);
        checkOutput("coinc.last", 4'b0001, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'b0000, 16'h0001, 4'b0001);
        checkOutput("coinc.end", 4'b0000, 0, 1, 0, 0);
        applyStimulus(0, 1, 4'b0000, 16'h0001, 4'b0000);
        checkOutput("coinc.idle", 4'b0000, 0, 1, 0, 0);

        // Bounded wait for a grant to requester 2.
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            applyStimulus(0, 1, 4'b0100, 16'h0200, 4'b0000);
            if (gnt_start === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL wait.grant got=timeout want=gnt_start within 8 cycles");
        end else begin
            checkOutput("wait.grant", 4'b0100, 2, 1, 1, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
